// File: rtl/interrupt_controller.sv
// Eight-line rising-edge interrupt controller with mask, vector base and a REQ/ACK handshake
// to the microcode sequencer. Define IRQ_SYNC_EN to add a 2-flop input synchronizer.
module interrupt_controller #(
  parameter int IRQ_EN_BIT = 1
) (
  input  logic       clk,
  input  logic       arst,
  input  logic [7:0] irq_in,
  input  logic [7:0] z_bus,
  input  logic [7:0] cpu_status,
  input  logic       ctrl_irq_masks_wrt,
  input  logic       ctrl_int_vector_wrt,
  input  logic       ctrl_int_ack,
  input  logic       ctrl_clear_all_ints,
  output logic       int_pending,
  output logic [7:0] int_vector,
  output logic [2:0] int_req_num,
  output logic [7:0] irq_masks,
  output logic [7:0] int_status
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_ACK} state_t;

  state_t     r_state;
  logic       r_int_pending;
  logic [7:0] r_pending;
  logic [7:0] r_masks;
  logic [3:0] r_vector_base;
  logic [2:0] r_req_num;
  logic [7:0] r_irq_hist;

  logic [7:0] w_irq_sampled;
  logic [7:0] w_rise;
  logic [7:0] w_eligible;
  logic [7:0] w_ack_clear;
  logic [2:0] w_winner;
  logic       w_irq_en;
  logic       w_ack_fire;
  logic       w_unused;

`ifdef IRQ_SYNC_EN
  logic [7:0] r_sync1;
  logic [7:0] r_sync2;

  always_ff @(posedge clk) begin
    if (arst) begin
      r_sync1 <= 8'h00;
      r_sync2 <= 8'h00;
    end else begin
      r_sync1 <= irq_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_irq_sampled = r_sync2;
`else
  assign w_irq_sampled = irq_in;
`endif

  always_comb begin
    w_rise     = w_irq_sampled & ~r_irq_hist;
    w_eligible = r_pending & r_masks;
    w_irq_en   = cpu_status[IRQ_EN_BIT];
    // Scan downward so the lowest-numbered eligible line is the last one written.
    w_winner   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_eligible[i]) w_winner = 3'(i);
    end
    w_ack_fire  = (r_state == ST_REQ) && ctrl_int_ack && (|w_eligible);
    w_ack_clear = w_ack_fire ? (8'h01 << w_winner) : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      r_state       <= ST_IDLE;
      r_int_pending <= 1'b0;
      r_pending     <= 8'h00;
      r_masks       <= 8'h00;
      r_vector_base <= 4'h0;
      r_req_num     <= 3'd0;
      r_irq_hist    <= 8'h00;
    end else begin
      r_irq_hist <= w_irq_sampled;
      if (ctrl_irq_masks_wrt)  r_masks       <= z_bus;
      if (ctrl_int_vector_wrt) r_vector_base <= z_bus[7:4];

      if (ctrl_clear_all_ints) begin
        r_pending     <= 8'h00;
        r_state       <= ST_IDLE;
        r_int_pending <= 1'b0;
      end else begin
        // A fresh edge on the acknowledged line re-arms it rather than being lost.
        r_pending <= (r_pending & ~w_ack_clear) | w_rise;
        case (r_state)
          ST_IDLE: begin
            if ((|w_eligible) && w_irq_en) begin
              r_state       <= ST_REQ;
              r_int_pending <= 1'b1;
            end
          end
          ST_REQ: begin
            if (w_ack_fire) begin
              r_req_num     <= w_winner;
              r_state       <= ST_ACK;
              r_int_pending <= 1'b0;
            end else if (!(|w_eligible) || !w_irq_en) begin
              r_state       <= ST_IDLE;
              r_int_pending <= 1'b0;
            end
          end
          default: begin
            r_state       <= ST_IDLE;
            r_int_pending <= 1'b0;
          end
        endcase
      end
    end
  end

  assign int_pending = r_int_pending;
  assign int_vector  = {r_vector_base, r_req_num, 1'b0};
  assign int_req_num = r_req_num;
  assign irq_masks   = r_masks;
  assign int_status  = r_pending;

  assign w_unused = ^{z_bus[3:0], cpu_status};

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed-vector bench for interrupt_controller; inputs are driven and outputs checked on the
// falling edge, with extra latency applied when IRQ_SYNC_EN is defined.
module tb_interrupt_controller;

`ifdef IRQ_SYNC_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       arst;
  logic [7:0] irq_in;
  logic [7:0] z_bus;
  logic [7:0] cpu_status;
  logic       ctrl_irq_masks_wrt;
  logic       ctrl_int_vector_wrt;
  logic       ctrl_int_ack;
  logic       ctrl_clear_all_ints;
  logic       int_pending;
  logic [7:0] int_vector;
  logic [2:0] int_req_num;
  logic [7:0] irq_masks;
  logic [7:0] int_status;

  int errors = 0;
  int checks = 0;

  interrupt_controller #(.IRQ_EN_BIT(1)) dut (
    .clk                 (clk),
    .arst                (arst),
    .irq_in              (irq_in),
    .z_bus               (z_bus),
    .cpu_status          (cpu_status),
    .ctrl_irq_masks_wrt  (ctrl_irq_masks_wrt),
    .ctrl_int_vector_wrt (ctrl_int_vector_wrt),
    .ctrl_int_ack        (ctrl_int_ack),
    .ctrl_clear_all_ints (ctrl_clear_all_ints),
    .int_pending         (int_pending),
    .int_vector          (int_vector),
    .int_req_num         (int_req_num),
    .irq_masks           (irq_masks),
    .int_status          (int_status)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    irq_in = 8'h00;
    arst = 1'b1;
    tick();
    arst = 1'b0;
  endtask

  task automatic write_masks(input logic [7:0] v);
    z_bus = v;
    ctrl_irq_masks_wrt = 1'b1;
    tick();
    ctrl_irq_masks_wrt = 1'b0;
  endtask

  task automatic write_vector(input logic [7:0] v);
    z_bus = v;
    ctrl_int_vector_wrt = 1'b1;
    tick();
    ctrl_int_vector_wrt = 1'b0;
  endtask

  task automatic pulse_ack();
    ctrl_int_ack = 1'b1;
    tick();
    ctrl_int_ack = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    checks++; if (int_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b want 0", int_pending); end
    checks++; if (irq_masks !== 8'h00) begin errors++; $display("FAIL reset_masks: got %h want 00", irq_masks); end
    checks++; if (int_status !== 8'h00) begin errors++; $display("FAIL reset_status: got %h want 00", int_status); end
    checks++; if (int_vector !== 8'h00) begin errors++; $display("FAIL reset_vector: got %h want 00", int_vector); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    do_reset();
    write_masks(8'hFF);
    irq_in = 8'h08;
    repeat (EXTRA) tick();
    tick();
    checks++; if (int_status !== 8'h08) begin errors++; $display("FAIL basic_status: got %h want 08", int_status); end
    checks++; if (int_pending !== 1'b0) begin errors++; $display("FAIL basic_early: got %b want 0", int_pending); end
    tick();
    checks++; if (int_pending !== 1'b1) begin errors++; $display("FAIL basic_pending: got %b want 1", int_pending); end
    irq_in = 8'h00;
    pulse_ack();
    checks++; if (int_req_num !== 3'd3) begin errors++; $display("FAIL basic_reqnum: got %0d want 3", int_req_num); end
    checks++; if (int_status !== 8'h00) begin errors++; $display("FAIL basic_cleared: got %h want 00", int_status); end
    checks++; if (int_pending !== 1'b0) begin errors++; $display("FAIL basic_ackdrop: got %b want 0", int_pending); end
    $display("test_basic done");
  endtask

  task automatic test_vector();
    do_reset();
    write_masks(8'hFF);
    write_vector(8'hA0);
    irq_in = 8'h24;
    repeat (EXTRA + 2) tick();
    checks++; if (int_pending !== 1'b1) begin errors++; $display("FAIL vec_pending: got %b want 1", int_pending); end
    pulse_ack();
    checks++; if (int_vector !== 8'hA4) begin errors++; $display("FAIL vec_first: got %h want a4", int_vector); end
    checks++; if (int_status !== 8'h20) begin errors++; $display("FAIL vec_status: got %h want 20", int_status); end
    tick();
    checks++; if (int_vector !== 8'hA4) begin errors++; $display("FAIL vec_stable: got %h want a4", int_vector); end
    tick();
    checks++; if (int_pending !== 1'b1) begin errors++; $display("FAIL vec_rereq: got %b want 1", int_pending); end
    pulse_ack();
    checks++; if (int_vector !== 8'hAA) begin errors++; $display("FAIL vec_second: got %h want aa", int_vector); end
    checks++; if (int_status !== 8'h00) begin errors++; $display("FAIL vec_status2: got %h want 00", int_status); end
    irq_in = 8'h00;
    $display("test_vector done");
  endtask

  task automatic test_masked();
    do_reset();
    irq_in = 8'h02;
    repeat (EXTRA + 1) tick();
    checks++; if (int_status !== 8'h02) begin errors++; $display("FAIL mask_status: got %h want 02", int_status); end
    tick();
    tick();
    checks++; if (int_pending !== 1'b0) begin errors++; $display("FAIL mask_blocked: got %b want 0", int_pending); end
    write_masks(8'h02);
    checks++; if (irq_masks !== 8'h02) begin errors++; $display("FAIL mask_written: got %h want 02", irq_masks); end
    tick();
    checks++; if (int_pending !== 1'b1) begin errors++; $display("FAIL mask_unblocked: got %b want 1", int_pending); end
    irq_in = 8'h00;
    $display("test_masked done");
  endtask

  task automatic test_enable_and_ignore();
    do_reset();
    write_masks(8'hFF);
    cpu_status = 8'h00;
    irq_in = 8'h20;
    repeat (EXTRA + 3) tick();
    checks++; if (int_pending !== 1'b0) begin errors++; $display("FAIL en_gated: got %b want 0", int_pending); end
    pulse_ack();
    checks++; if (int_status !== 8'h20) begin errors++; $display("FAIL ack_ignored_status: got %h want 20", int_status); end
    checks++; if (int_req_num !== 3'd0) begin errors++; $display("FAIL ack_ignored_num: got %0d want 0", int_req_num); end
    cpu_status = 8'h02;
    tick();
    checks++; if (int_pending !== 1'b1) begin errors++; $display("FAIL en_request: got %b want 1", int_pending); end
    cpu_status = 8'h00;
    tick();
    checks++; if (int_pending !== 1'b0) begin errors++; $display("FAIL withdraw: got %b want 0", int_pending); end
    checks++; if (int_status !== 8'h20) begin errors++; $display("FAIL withdraw_status: got %h want 20", int_status); end
    cpu_status = 8'h02;
    irq_in = 8'h00;
    $display("test_enable_and_ignore done");
  endtask

  task automatic test_clear_all();
    do_reset();
    write_masks(8'hFF);
    irq_in = 8'h40;
    repeat (EXTRA + 2) tick();
    pulse_ack();
    checks++; if (int_req_num !== 3'd6) begin errors++; $display("FAIL clr_setup: got %0d want 6", int_req_num); end
    irq_in = 8'h10;
    repeat (EXTRA + 2) tick();
    checks++; if (int_pending !== 1'b1) begin errors++; $display("FAIL clr_req: got %b want 1", int_pending); end
    ctrl_clear_all_ints = 1'b1;
    ctrl_int_ack = 1'b1;
    tick();
    ctrl_clear_all_ints = 1'b0;
    ctrl_int_ack = 1'b0;
    checks++; if (int_status !== 8'h00) begin errors++; $display("FAIL clr_status: got %h want 00", int_status); end
    checks++; if (int_pending !== 1'b0) begin errors++; $display("FAIL clr_pending: got %b want 0", int_pending); end
    checks++; if (int_req_num !== 3'd6) begin errors++; $display("FAIL clr_reqnum: got %0d want 6", int_req_num); end
    tick();
    checks++; if (int_pending !== 1'b0) begin errors++; $display("FAIL clr_idle: got %b want 0", int_pending); end
    irq_in = 8'h00;
    $display("test_clear_all done");
  endtask

  task automatic test_set_wins();
    do_reset();
    write_masks(8'hFF);
    irq_in = 8'h01;
    repeat (EXTRA + 2) tick();
    checks++; if (int_pending !== 1'b1) begin errors++; $display("FAIL setwin_req: got %b want 1", int_pending); end
    irq_in = 8'h00;
    tick();
    irq_in = 8'h01;
    repeat (EXTRA) tick();
    pulse_ack();
    checks++; if (int_status[0] !== 1'b1) begin errors++; $display("FAIL setwin_status: got %b want 1", int_status[0]); end
    checks++; if (int_req_num !== 3'd0) begin errors++; $display("FAIL setwin_num: got %0d want 0", int_req_num); end
    tick();
    tick();
    checks++; if (int_pending !== 1'b1) begin errors++; $display("FAIL setwin_rereq: got %b want 1", int_pending); end
    irq_in = 8'h00;
    $display("test_set_wins done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    write_masks(8'hFF);
    irq_in = 8'h80;
    repeat (EXTRA + 2) tick();
    checks++; if (int_pending !== 1'b1) begin errors++; $display("FAIL rstmid_req: got %b want 1", int_pending); end
    arst = 1'b1;
    tick();
    arst = 1'b0;
    checks++; if (int_pending !== 1'b0) begin errors++; $display("FAIL rstmid_pending: got %b want 0", int_pending); end
    checks++; if (irq_masks !== 8'h00) begin errors++; $display("FAIL rstmid_masks: got %h want 00", irq_masks); end
    checks++; if (int_status !== 8'h00) begin errors++; $display("FAIL rstmid_status: got %h want 00", int_status); end
    irq_in = 8'h00;
    $display("test_reset_mid done");
  endtask

  initial begin
    arst = 1'b1;
    irq_in = 8'h00;
    z_bus = 8'h00;
    cpu_status = 8'h02;
    ctrl_irq_masks_wrt = 1'b0;
    ctrl_int_vector_wrt = 1'b0;
    ctrl_int_ack = 1'b0;
    ctrl_clear_all_ints = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_vector();
    test_masked();
    test_enable_and_ignore();
    test_clear_all();
    test_set_wins();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
